// File: rtl/phy_ctrl_pkg.sv
// Shared definitions for the PHY transmit side of the dibit FIFO: read-control
// state encoding, preamble/SFD constants, default frame geometry, and a helper
// that maps a preamble dibit index to the dibit sent on the line.
package phy_ctrl_pkg;

  localparam int DEFAULT_DEPTH     = 288;
  localparam int DEFAULT_ADDR_W    = 9;
  localparam int DEFAULT_IFG_TICKS = 48;

  localparam logic [7:0] PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0] SFD_BYTE        = 8'hD5;
  localparam int         PREAMBLE_DIBITS = 32;
  localparam int         PREAMBLE_IDX_W  = $clog2(PREAMBLE_DIBITS);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_PRIME    = 3'd2,
    ST_STREAM   = 3'd3,
    ST_GAP      = 3'd4
  } rd_state_t;

  // The last four dibits belong to the SFD byte; each byte goes out MSB pair first.
  function automatic logic [1:0] preamble_dibit(input logic [PREAMBLE_IDX_W-1:0] idx);
    logic [7:0] byte_val;
    byte_val = (idx >= PREAMBLE_IDX_W'(PREAMBLE_DIBITS - 4)) ? SFD_BYTE : PREAMBLE_BYTE;
    case (idx[1:0])
      2'd0:    preamble_dibit = byte_val[7:6];
      2'd1:    preamble_dibit = byte_val[5:4];
      2'd2:    preamble_dibit = byte_val[3:2];
      default: preamble_dibit = byte_val[1:0];
    endcase
  endfunction

endpackage

// File: rtl/phy_preamble_gen.sv
// Preamble/SFD dibit generator: translates a dibit index (0..31) into the dibit
// that belongs on the line at that position. Only present when the optional
// FIFO_READ_PREAMBLE_EN feature is built, so the default build carries no
// unused module.
`ifdef FIFO_READ_PREAMBLE_EN
module phy_preamble_gen
  import phy_ctrl_pkg::*;
(
  input  logic [PREAMBLE_IDX_W-1:0] i_index,
  output logic [1:0]                o_dibit
);

  assign o_dibit = preamble_dibit(i_index);

endmodule
`endif

// File: rtl/fifo_read_control.sv
// FIFO read controller: once the writer reports a full frame, reads DEPTH
// dibits back from the dual-port RAM in ascending address order and streams
// them onto the 2-bit PHY bus, one per i_tx_tick, followed by an inter-frame
// gap of IFG_TICKS ticks. Each read is issued one tick ahead of its use, so the
// RAM's one-clock read latency is hidden behind the tick spacing.
// Optional feature macro: FIFO_READ_PREAMBLE_EN prepends 7x 0x55 + SFD 0xD5.
module fifo_read_control
  import phy_ctrl_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int IFG_TICKS = DEFAULT_IFG_TICKS
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_frame_ready,
  input  logic              i_tx_tick,
  input  logic [1:0]        i_data_read,
  output logic [ADDR_W-1:0] o_addr_read,
  output logic              o_enab_read,
  output logic [1:0]        o_txd,
  output logic              o_tx_en,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_drop
);

  localparam int GAP_W = $clog2(IFG_TICKS + 1);
  // Address counter values at which the last dibit is sent and the frame closes.
  localparam logic [ADDR_W:0]  CNT_LAST_DIBIT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]  CNT_CLOSE      = (ADDR_W + 1)'(DEPTH + 1);
  localparam logic [GAP_W-1:0] GAP_LAST       = GAP_W'(IFG_TICKS - 1);

  rd_state_t        state;
  logic [ADDR_W:0]  addr_cnt;
  logic [GAP_W-1:0] gap_cnt;

`ifdef FIFO_READ_PREAMBLE_EN
  localparam logic [PREAMBLE_IDX_W-1:0] PRE_LAST = PREAMBLE_IDX_W'(PREAMBLE_DIBITS - 1);

  logic [PREAMBLE_IDX_W-1:0] pre_idx;
  logic [1:0]                pre_dibit;

  phy_preamble_gen u_preamble_gen (
    .i_index (pre_idx),
    .o_dibit (pre_dibit)
  );
`endif

  // Frame sequencer: accept, optional preamble, prime first read, stream, gap.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= ST_IDLE;
      addr_cnt    <= '0;
      gap_cnt     <= '0;
`ifdef FIFO_READ_PREAMBLE_EN
      pre_idx     <= '0;
`endif
      o_addr_read <= '0;
      o_enab_read <= 1'b0;
      o_txd       <= 2'b00;
      o_tx_en     <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_enab_read <= 1'b0;
      o_done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_frame_ready) begin
            o_busy <= 1'b1;
`ifdef FIFO_READ_PREAMBLE_EN
            pre_idx <= '0;
            state   <= ST_PREAMBLE;
`else
            o_addr_read <= '0;
            o_enab_read <= 1'b1;
            state       <= ST_PRIME;
`endif
          end
        end
`ifdef FIFO_READ_PREAMBLE_EN
        ST_PREAMBLE: begin
          if (i_tx_tick) begin
            o_txd   <= pre_dibit;
            o_tx_en <= 1'b1;
            if (pre_idx == PRE_LAST) begin
              o_addr_read <= '0;
              o_enab_read <= 1'b1;
              state       <= ST_PRIME;
            end else begin
              pre_idx <= pre_idx + 1'b1;
            end
          end
        end
`endif
        ST_PRIME: begin
          addr_cnt <= (ADDR_W + 1)'(1);
          state    <= ST_STREAM;
        end
        ST_STREAM: begin
          if (i_tx_tick) begin
            if (addr_cnt == CNT_CLOSE) begin
              o_txd   <= 2'b00;
              o_tx_en <= 1'b0;
              o_done  <= 1'b1;
              gap_cnt <= '0;
              state   <= ST_GAP;
            end else begin
              o_txd   <= i_data_read;
              o_tx_en <= 1'b1;
              if (addr_cnt != CNT_LAST_DIBIT) begin
                o_addr_read <= addr_cnt[ADDR_W-1:0];
                o_enab_read <= 1'b1;
              end
              addr_cnt <= addr_cnt + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (i_tx_tick) begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt  <= '0;
              addr_cnt <= '0;
              o_busy   <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Flag a frame-ready that lands while a frame is still in flight; it is not queued.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_drop <= 1'b0;
    end else begin
      o_drop <= i_frame_ready & o_busy;
    end
  end

endmodule

// File: tb/tb_fifo_read_control.sv
// Testbench for fifo_read_control: RAM model with one-clock read latency,
// randomized tick pacing, and a frame-level reference built from the RAM
// contents (plus 0x55/0xD5 preamble when FIFO_READ_PREAMBLE_EN is defined).
module tb_fifo_read_control;

  localparam int DEPTH     = 288;
  localparam int ADDR_W    = 9;
  localparam int IFG_TICKS = 48;
  localparam int BUDGET    = 4000;
`ifdef FIFO_READ_PREAMBLE_EN
  localparam int PRE_BYTES = 8;
`else
  localparam int PRE_BYTES = 0;
`endif

  logic              i_clock = 1'b0;
  logic              i_reset_n;
  logic              i_frame_ready;
  logic              i_tx_tick;
  logic [1:0]        i_data_read = 2'b00;
  logic [ADDR_W-1:0] o_addr_read;
  logic              o_enab_read;
  logic [1:0]        o_txd;
  logic              o_tx_en;
  logic              o_busy;
  logic              o_done;
  logic              o_drop;

  int checks = 0;
  int errors = 0;

  logic [1:0] mem [0:DEPTH-1];
  logic [1:0] exp_q[$];

  // Monitor results
  logic [1:0]        tx_q[$];
  logic [ADDR_W-1:0] rd_q[$];
  int   done_cnt, gap_ticks, drop_cnt, hold_err, txen_falls, txd_after_fall;
  logic in_gap = 1'b0;
  logic tick_q = 1'b0;
  logic prev_tx_en = 1'b0, prev_busy = 1'b0;
  logic [1:0] prev_txd = 2'b00;

  // Tick pacing
  int tick_min = 4;
  int tick_max = 4;
  int tick_wait = 0;
  int tick_period = 4;

  fifo_read_control #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .IFG_TICKS (IFG_TICKS)
  ) dut (
    .i_clock       (i_clock),
    .i_reset_n     (i_reset_n),
    .i_frame_ready (i_frame_ready),
    .i_tx_tick     (i_tx_tick),
    .i_data_read   (i_data_read),
    .o_addr_read   (o_addr_read),
    .o_enab_read   (o_enab_read),
    .o_txd         (o_txd),
    .o_tx_en       (o_tx_en),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_drop        (o_drop)
  );

  // Free-running system clock
  always #5 i_clock = ~i_clock;

  // Dual-port RAM read side: data appears the clock after a read enable and holds
  always @(posedge i_clock) begin
    if (o_enab_read && int'(o_addr_read) < DEPTH) i_data_read <= mem[o_addr_read];
  end

  // Tick strobe generator with spacing drawn from [tick_min, tick_max] clocks
  initial begin
    i_tx_tick = 1'b0;
    forever begin
      @(posedge i_clock);
      #1;
      tick_wait++;
      if (tick_wait >= tick_period) begin
        i_tx_tick   = 1'b1;
        tick_wait   = 0;
        tick_period = $urandom_range(tick_max, tick_min);
      end else begin
        i_tx_tick = 1'b0;
      end
    end
  end

  // Remember whether the DUT saw a tick at this edge
  always @(posedge i_clock) tick_q = i_tx_tick;

  // Frame-level monitor: collects streamed dibits, reads, pulses and gap length
  always @(negedge i_clock) begin
    if (tick_q) begin
      if (o_tx_en) tx_q.push_back(o_txd);
      if (in_gap) gap_ticks++;
    end else if (o_tx_en !== prev_tx_en || o_txd !== prev_txd) begin
      hold_err++;
    end
    if (prev_tx_en && !o_tx_en) begin
      txen_falls++;
      txd_after_fall = int'(o_txd);
    end
    if (o_done) begin
      done_cnt++;
      in_gap = 1'b1;
    end
    if (o_enab_read) rd_q.push_back(o_addr_read);
    if (o_drop) drop_cnt++;
    if (prev_busy && !o_busy) in_gap = 1'b0;
    prev_tx_en = o_tx_en;
    prev_txd   = o_txd;
    prev_busy  = o_busy;
  end

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic clearMonitor();
    tx_q.delete();
    rd_q.delete();
    done_cnt       = 0;
    gap_ticks      = 0;
    drop_cnt       = 0;
    hold_err       = 0;
    txen_falls     = 0;
    txd_after_fall = 0;
    in_gap         = 1'b0;
  endtask

  task automatic fillMem(input bit random_fill);
    for (int n = 0; n < DEPTH; n++) mem[n] = random_fill ? 2'($urandom) : 2'(n);
  endtask

  // Reference: optional preamble bytes MSB pair first, then RAM in address order
  task automatic buildExpected();
    logic [7:0] b;
    exp_q.delete();
    for (int k = 0; k < PRE_BYTES; k++) begin
      b = (k == PRE_BYTES - 1) ? 8'hD5 : 8'h55;
      for (int p = 3; p >= 0; p--) exp_q.push_back(2'((b >> (2 * p)) & 8'h03));
    end
    for (int n = 0; n < DEPTH; n++) exp_q.push_back(mem[n]);
  endtask

  // Pulse i_frame_ready for one clock and confirm the frame was taken
  task automatic applyStimulus(input string tag);
    @(posedge i_clock);
    #1 i_frame_ready = 1'b1;
    @(posedge i_clock);
    #1 i_frame_ready = 1'b0;
    checkOutput({tag, " busy_rise"}, int'(o_busy), 1);
    checkOutput({tag, " no_drop_on_accept"}, int'(o_drop), 0);
  endtask

  task automatic waitIdle(input string tag);
    int k = 0;
    while (o_busy !== 1'b0 && k < BUDGET) begin
      @(negedge i_clock);
      #1;
      k++;
    end
    checkOutput({tag, " idle_reached"}, int'(o_busy), 0);
  endtask

  task automatic waitDibits(input string tag, input int count);
    int k = 0;
    while (tx_q.size() < count && k < BUDGET) begin
      @(negedge i_clock);
      #1;
      k++;
    end
    checkOutput({tag, " dibits_reached"}, int'(tx_q.size() >= count), 1);
  endtask

  task automatic checkFrame(input string tag);
    int n;
    checkOutput({tag, " stream_len"}, tx_q.size(), exp_q.size());
    n = (tx_q.size() < exp_q.size()) ? tx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s dibit%0d", tag, i), int'(tx_q[i]), int'(exp_q[i]));
    checkOutput({tag, " read_count"}, rd_q.size(), DEPTH);
    for (int i = 0; i < rd_q.size() && i < DEPTH; i++)
      checkOutput($sformatf("%s read_addr%0d", tag, i), int'(rd_q[i]), i);
    checkOutput({tag, " done_pulses"}, done_cnt, 1);
    checkOutput({tag, " gap_ticks"}, gap_ticks, IFG_TICKS);
    checkOutput({tag, " tx_en_falls"}, txen_falls, 1);
    checkOutput({tag, " txd_after_frame"}, txd_after_fall, 0);
    checkOutput({tag, " hold_between_ticks"}, hold_err, 0);
  endtask

  // Safety net in case something blocks outside the bounded waits
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence
  initial begin
    i_reset_n     = 1'b1;
    i_frame_ready = 1'b0;
    clearMonitor();

    // Reset state
    #1 i_reset_n = 1'b0;
    #2;
    checkOutput("reset addr_read", int'(o_addr_read), 0);
    checkOutput("reset enab_read", int'(o_enab_read), 0);
    checkOutput("reset txd", int'(o_txd), 0);
    checkOutput("reset tx_en", int'(o_tx_en), 0);
    checkOutput("reset busy", int'(o_busy), 0);
    checkOutput("reset done", int'(o_done), 0);
    checkOutput("reset drop", int'(o_drop), 0);
    repeat (3) @(posedge i_clock);
    @(negedge i_clock) i_reset_n = 1'b1;
    @(negedge i_clock);
    #1 clearMonitor();

    // Basic frame: addr n holds n[1:0], tick every 4 clocks
    $display("[TB] basic frame");
    fillMem(1'b0);
    buildExpected();
    applyStimulus("basic");
    waitIdle("basic");
    checkFrame("basic");
    checkOutput("basic drop_count", drop_cnt, 0);

    // Drop: second frame-ready mid-stream with random data and tick spacing
    $display("[TB] drop during stream");
    tick_min = 2;
    tick_max = 5;
    clearMonitor();
    fillMem(1'b1);
    buildExpected();
    applyStimulus("drop");
    waitDibits("drop", 150);
    i_frame_ready = 1'b1;
    @(posedge i_clock);
    #1 i_frame_ready = 1'b0;
    checkOutput("drop pulse", int'(o_drop), 1);
    @(posedge i_clock);
    #1 checkOutput("drop single_pulse", int'(o_drop), 0);
    waitIdle("drop");
    checkFrame("drop");
    checkOutput("drop drop_count", drop_cnt, 1);
    repeat (200) @(negedge i_clock);
    #1;
    checkOutput("drop no_second_frame_busy", int'(o_busy), 0);
    checkOutput("drop no_second_frame_reads", rd_q.size(), DEPTH);

    // Reset mid-frame at dibit 100, then a fresh frame restarts at address 0
    $display("[TB] reset mid-frame");
    clearMonitor();
    fillMem(1'b1);
    buildExpected();
    applyStimulus("midreset");
    waitDibits("midreset", 100);
    i_reset_n = 1'b0;
    #1;
    checkOutput("midreset tx_en", int'(o_tx_en), 0);
    checkOutput("midreset txd", int'(o_txd), 0);
    checkOutput("midreset busy", int'(o_busy), 0);
    checkOutput("midreset enab_read", int'(o_enab_read), 0);
    checkOutput("midreset addr_read", int'(o_addr_read), 0);
    repeat (2) @(negedge i_clock);
    i_reset_n = 1'b1;
    @(negedge i_clock);
    #1;
    checkOutput("midreset stays_idle", int'(o_busy), 0);
    clearMonitor();
    fillMem(1'b1);
    buildExpected();
    applyStimulus("restart");
    waitIdle("restart");
    checkFrame("restart");

    // Back-to-back: frame-ready on the first clock with o_busy low is accepted
    $display("[TB] back-to-back frames");
    clearMonitor();
    fillMem(1'b1);
    buildExpected();
    applyStimulus("b2b_a");
    waitIdle("b2b_a");
    i_frame_ready = 1'b1;
    checkFrame("b2b_a");
    clearMonitor();
    @(posedge i_clock);
    #1 i_frame_ready = 1'b0;
    checkOutput("b2b accepted", int'(o_busy), 1);
    waitIdle("b2b_b");
    checkFrame("b2b_b");
    checkOutput("b2b drop_count", drop_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
